// File: rtl/triwave_sequencer_pkg.sv
// Shared types for the triangle-wave note sequencer: FSM state encoding,
// note-table entry layout and the rest (silent) scale value.
package triwave_sequencer_pkg;

  localparam int unsigned SCALE_W   = 6;
  // Upper bound on the duration field; entries store DUR_W bits zero-extended.
  localparam int unsigned DUR_W_MAX = 32;

  localparam logic [SCALE_W-1:0] REST_SCALE = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [SCALE_W-1:0]   scale;
    logic [DUR_W_MAX-1:0] dur;
  } note_t;

  // Build a table entry from host write fields.
  function automatic note_t make_note(input logic [SCALE_W-1:0]   scale,
                                      input logic [DUR_W_MAX-1:0] dur);
    note_t n;
    n.scale = scale;
    n.dur   = dur;
    return n;
  endfunction

endpackage

// File: rtl/triwave_sequencer_tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal
// count, giving one duration tick every TICK_DIV enabled cycles.
// Ports:
//   i_clk     - clock
//   i_rst     - synchronous active-high reset
//   i_clr     - synchronous clear of the count
//   i_en      - count enable
//   o_tick_c  - combinational tick, high on the enabled terminal-count cycle
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned PS_W = $clog2(TICK_DIV);

  logic [PS_W-1:0] r_count;
  logic            w_tc;

  assign w_tc     = (r_count == PS_W'(TICK_DIV - 1));
  assign o_tick_c = i_en && w_tc;

  // Wrapping divide-by-TICK_DIV counter.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_tc ? '0 : r_count + PS_W'(1);
    end
  end

endmodule

// File: rtl/triwave_sequencer.sv
// triwave_sequencer: plays a programmable table of (scale, duration) notes
// into the triangle-wave generator, with a silent gap between notes.
// Ports:
//   sysclk, Reset            - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_scale/wr_dur - note table write port (any state)
//   length, loop_en          - entries to play, repeat-from-0 enable
//   start, stop              - single-cycle play / abort requests
//   Scale, Enable_SW_2       - generator configuration and enable
//   busy, done, cur_index    - status: active, end pulse, loaded entry
// DUR_W must not exceed the package DUR_W_MAX.
module triwave_sequencer
  import triwave_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned GAP_CYC  = 1000
) (
  input  logic                     sysclk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [5:0]               wr_scale,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic [$clog2(DEPTH):0]   length,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic [5:0]               Scale,
  output logic                     Enable_SW_2,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_index
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  note_t              r_table [DEPTH];
  state_t             r_state;
  logic [SCALE_W-1:0] r_scale;
  logic               r_enable;
  logic               r_busy;
  logic               r_done;
  logic               r_abort;
  logic [IDX_W-1:0]   r_index;
  logic [LEN_W-1:0]   r_length;
  logic [DUR_W-1:0]   r_remain;
  logic [GAP_W-1:0]   r_gap_cnt;

  note_t              w_entry;
  logic [DUR_W-1:0]   w_entry_dur;
  logic               w_tick;
  logic               w_gap_last;
  logic               w_more;

  // Note table; not reset so a program survives a sequencer reset.
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      r_table[wr_addr] <= make_note(wr_scale, DUR_W_MAX'(wr_dur));
    end
  end

  assign w_entry     = r_table[r_index];
  assign w_entry_dur = DUR_W'(w_entry.dur);
  assign w_gap_last  = (r_gap_cnt == GAP_W'(GAP_CYC - 1));
  assign w_more      = (LEN_W'(r_index) + LEN_W'(1)) < r_length;

  // Prescaler runs only in PLAY and restarts from 0 for every note.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .i_clk    (sysclk),
    .i_rst    (Reset),
    .i_clr    (r_state != S_PLAY),
    .i_en     (r_state == S_PLAY),
    .o_tick_c (w_tick)
  );

  // Sequencer FSM with registered outputs. An abort (stop or zero length)
  // spends one silent DONE cycle before the done pulse; r_abort marks it.
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_scale   <= '0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_index   <= '0;
      r_length  <= '0;
      r_remain  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (stop && (r_state == S_LOAD || r_state == S_PLAY || r_state == S_GAP)) begin
        r_state  <= S_DONE;
        r_enable <= 1'b0;
        r_busy   <= 1'b0;
        r_abort  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !stop) begin
              if (length == '0) begin
                r_state <= S_DONE;
                r_abort <= 1'b1;
              end else begin
                r_state  <= S_LOAD;
                r_length <= length;
                r_index  <= '0;
                r_busy   <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            r_scale   <= w_entry.scale;
            r_remain  <= w_entry_dur;
            r_gap_cnt <= '0;
            if (w_entry_dur == '0) begin
              r_enable <= 1'b0;
              r_state  <= S_GAP;
            end else begin
              r_enable <= (w_entry.scale != REST_SCALE);
              r_state  <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (w_tick) begin
              r_remain <= r_remain - DUR_W'(1);
              if (r_remain == DUR_W'(1)) begin
                r_enable  <= 1'b0;
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (w_gap_last) begin
              r_gap_cnt <= '0;
              if (w_more) begin
                r_index <= r_index + IDX_W'(1);
                r_state <= S_LOAD;
              end else if (loop_en) begin
                r_index <= '0;
                r_state <= S_LOAD;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          S_DONE: begin
            if (r_abort) begin
              r_abort <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign Scale       = r_scale;
  assign Enable_SW_2 = r_enable;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cur_index   = r_index;

endmodule

// File: doc/triwave_sequencer.md
# triwave_sequencer

Playback controller for the triangle-wave tone generator. Holds a small programmable table of (scale, duration) notes and, on command, steps through it, driving the generator's `Scale` and `Enable_SW_2` inputs so it plays a timed note sequence with a silent gap between notes. It sits between the host/switch logic and the generator, which it configures and gates.

## Interface
- `DEPTH`, default 8: number of note-table entries (power of 2).
- `DUR_W`, default 12: duration field width, in ticks.
- `TICK_DIV`, default 50000: sysclk cycles per duration tick (≥2).
- `GAP_CYC`, default 1000: silent sysclk cycles between notes (≥1).
- `sysclk`, in, 1: the single clock.
- `Reset`, in, 1: reset; **synchronous and active-high**.
- `wr_en`, in, 1: table write strobe.
- `wr_addr`, in, log2(DEPTH): table write address.
- `wr_scale`, in, 6: scale value to store; 0 means rest.
- `wr_dur`, in, DUR_W: duration to store, in ticks.
- `length`, in, log2(DEPTH)+1: number of entries to play (0..DEPTH); sampled on accepted start.
- `loop_en`, in, 1: repeat from entry 0 after the last entry; sampled at each wrap.
- `start`, in, 1: single-cycle play request.
- `stop`, in, 1: single-cycle abort request.
- `Scale`, out, 6: scale value to the generator.
- `Enable_SW_2`, out, 1: generator enable.
- `busy`, out, 1: high from LOAD through GAP.
- `done`, out, 1: one-cycle pulse at sequence end or abort.
- `cur_index`, out, log2(DEPTH): entry currently loaded.

## Operation
- Table: DEPTH × (6+DUR_W) registers, written on `wr_en` in any state. A write to the entry currently playing takes effect only at that entry's next LOAD. Table contents are not cleared by `Reset`.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- **IDLE**: `start` with `length` ≥1 goes to LOAD with index 0. `start` with `length` = 0 goes straight to DONE.
- **LOAD**: latch `Scale` and the remaining tick count from table[index], clear the prescaler, then go to PLAY. If the duration is 0, skip PLAY: go directly to GAP with `Enable_SW_2` kept low.
- **PLAY**:
  - `Enable_SW_2` = 1 if `Scale` ≠ 0, else 0.
  - The prescaler counts 0..TICK_DIV-1; at terminal count it decrements the remaining ticks.
  - When the last tick expires, go to GAP.
- **GAP**: `Enable_SW_2` = 0 and `Scale` is held, for GAP_CYC cycles. Then:
  - if index < length-1: increment index and go to LOAD;
  - else if `loop_en`: index = 0, go to LOAD;
  - else go to DONE.
- **DONE**: pulse `done` for one cycle, drop `busy`, return to IDLE.
- `stop` in LOAD/PLAY/GAP goes to DONE next cycle, with `Enable_SW_2` forced low that cycle. `stop` in IDLE or DONE is ignored.
- `start` while busy is ignored. `start` and `stop` in the same cycle: stop wins (from IDLE, nothing happens).
- Counters saturate at neither end. Widths: prescaler is ceil(log2(TICK_DIV)); gap counter is ceil(log2(GAP_CYC)).

## Timing
- Reset values: `Scale` = 0, `Enable_SW_2` = 0, `busy` = 0, `done` = 0, `cur_index` = 0; state IDLE; all counters 0.
- `Reset` asserted mid-sequence: all outputs return to reset values on the next edge. No `done` pulse is emitted.
- `start` sampled at edge t:
  - LOAD in cycle t+1, with `busy` = 1 from t+1;
  - `Scale` and `Enable_SW_2` valid from t+2.
- Note length: exactly dur×TICK_DIV cycles with enable high, then GAP_CYC cycles low, then 1 LOAD cycle (also low). Note period = dur×TICK_DIV + GAP_CYC + 1.
- `done` is high in the cycle after the last GAP cycle, or after the `stop` cycle. `busy` is low in that same cycle.
- All outputs are registered.

## Structure
- Shared package holds:
  - the state enum (IDLE/LOAD/PLAY/GAP/DONE);
  - the note-entry struct {scale[5:0], dur[DUR_W-1:0]};
  - the REST scale constant (0).
- One sub-module: `tick_prescaler`. It is a clear/enable TICK_DIV counter emitting a one-cycle tick at terminal count.
- The table, FSM and gap counter live in the top module.

## Test plan
(All with TICK_DIV=4, GAP_CYC=2.)
- **Basic playback.** Table {(5,2),(9,1)}, `length`=2, `start` at t.
  - Enable high t+2..t+9 with Scale=5;
  - low t+10..t+12;
  - high t+13..t+16 with Scale=9;
  - `done` at t+19.
- **Rest and zero duration.** Entry (0,3) holds Enable low for 12 cycles with Scale=0. Entry (7,0) never raises Enable and goes LOAD→GAP.
- **Loop.** `loop_en`=1, `length`=1, entry (3,1): Enable pattern is 4 high / 3 low repeating. `cur_index` stays 0 and `done` never pulses.
- **Abort.** `stop` during PLAY: Enable low the next cycle, `done` pulses the cycle after, `busy` drops. `start`+`stop` together from IDLE: no activity.
- **Edge cases.** `length`=0 start gives `done` at t+2 and Enable never high. `start` while busy is ignored.
- **Reset and live writes.** `Reset` mid-PLAY: all outputs 0 next cycle, no `done`. A write to the current entry during PLAY leaves the current note unchanged; the new value is used on the next loop pass.
